// File: rtl/squeeze_weight_fetch_pkg.sv
// Shared lane constants, per-fire squeeze layer geometry and FSM state encoding
// for the squeeze weight fetcher.
package squeeze_weight_fetch_pkg;

  localparam int N_FILT  = 8;
  localparam int N_CH    = 16;
  localparam int WORD_W  = 16;
  localparam int LANE_W  = N_CH * WORD_W;
  localparam int W_OUT_W = N_FILT * LANE_W;
  localparam int B_OUT_W = N_FILT * WORD_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [9:0] in_ch;
    logic [6:0] out_ch;
  } geom_t;

  function automatic geom_t fire_geom(input logic [2:0] fire);
    geom_t g;
    case (fire)
      3'd0:    g = '{in_ch: 10'd64,  out_ch: 7'd16};
      3'd1:    g = '{in_ch: 10'd128, out_ch: 7'd16};
      3'd2:    g = '{in_ch: 10'd128, out_ch: 7'd32};
      3'd3:    g = '{in_ch: 10'd256, out_ch: 7'd32};
      3'd4:    g = '{in_ch: 10'd256, out_ch: 7'd48};
      3'd5:    g = '{in_ch: 10'd384, out_ch: 7'd48};
      3'd6:    g = '{in_ch: 10'd384, out_ch: 7'd64};
      default: g = '{in_ch: 10'd512, out_ch: 7'd64};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/squeeze_weight_fetch_if.sv
// Bus between the weight fetcher, the weight store (addresses/data/bias)
// and the PE array (captured beat plus valid/ready handshake).
interface squeeze_weight_fetch_if;
  import squeeze_weight_fetch_pkg::*;

  logic [2:0]         firesel;
  logic [31:0]        addressf1, addressf2, addressf3, addressf4;
  logic [31:0]        addressf5, addressf6, addressf7, addressf8;
  logic [31:0]        addressfiltf1, addressfiltf2, addressfiltf3, addressfiltf4;
  logic [31:0]        addressfiltf5, addressfiltf6, addressfiltf7, addressfiltf8;
  logic [LANE_W-1:0]  dataf1, dataf2, dataf3, dataf4;
  logic [LANE_W-1:0]  dataf5, dataf6, dataf7, dataf8;
  logic [WORD_W-1:0]  biasf1, biasf2, biasf3, biasf4;
  logic [WORD_W-1:0]  biasf5, biasf6, biasf7, biasf8;
  logic [W_OUT_W-1:0] w_out;
  logic [B_OUT_W-1:0] b_out;
  logic               out_valid;
  logic               out_ready;
  logic               first_grp;
  logic               last_grp;

  modport master (
    output firesel,
    output addressf1, addressf2, addressf3, addressf4,
    output addressf5, addressf6, addressf7, addressf8,
    output addressfiltf1, addressfiltf2, addressfiltf3, addressfiltf4,
    output addressfiltf5, addressfiltf6, addressfiltf7, addressfiltf8,
    input  dataf1, dataf2, dataf3, dataf4, dataf5, dataf6, dataf7, dataf8,
    input  biasf1, biasf2, biasf3, biasf4, biasf5, biasf6, biasf7, biasf8,
    output w_out, b_out, out_valid, first_grp, last_grp,
    input  out_ready
  );

  modport slave (
    input  firesel,
    input  addressf1, addressf2, addressf3, addressf4,
    input  addressf5, addressf6, addressf7, addressf8,
    input  addressfiltf1, addressfiltf2, addressfiltf3, addressfiltf4,
    input  addressfiltf5, addressfiltf6, addressfiltf7, addressfiltf8,
    output dataf1, dataf2, dataf3, dataf4, dataf5, dataf6, dataf7, dataf8,
    output biasf1, biasf2, biasf3, biasf4, biasf5, biasf6, biasf7, biasf8,
    input  w_out, b_out, out_valid, first_grp, last_grp,
    output out_ready
  );

endinterface

// File: rtl/sqw_addr_gen.sv
// Filter-group / channel-group counters and the per-lane weight and bias
// addresses derived from them; addresses read zero while not issuing.
module sqw_addr_gen
  import squeeze_weight_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic        active_i,
  input  logic [2:0]  fire_i,
  output logic [31:0] addr_o [N_FILT],
  output logic [31:0] filt_o [N_FILT],
  output logic        first_k_o,
  output logic        last_k_o,
  output logic        last_beat_o
);

  geom_t      geom;
  logic [5:0] n_k;
  logic [3:0] n_g;
  logic [4:0] k_q, k_d;
  logic [2:0] g_q, g_d;
  logic       k_last, g_last;

  assign geom   = fire_geom(fire_i);
  assign n_k    = 6'(geom.in_ch >> 4);
  assign n_g    = 4'(geom.out_ch >> 3);
  assign k_last = ({1'b0, k_q} == n_k - 6'd1);
  assign g_last = ({1'b0, g_q} == n_g - 4'd1);

  assign first_k_o   = (k_q == 5'd0);
  assign last_k_o    = k_last;
  assign last_beat_o = k_last && g_last;

  // Channel group is the inner loop; its wrap steps the filter group.
  always_comb begin
    k_d = k_q;
    g_d = g_q;
    if (clr_i) begin
      k_d = '0;
      g_d = '0;
    end else if (adv_i) begin
      if (k_last) begin
        k_d = '0;
        g_d = g_q + 3'd1;
      end else begin
        k_d = k_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      g_q <= '0;
    end else begin
      k_q <= k_d;
      g_q <= g_d;
    end
  end

  always_comb begin
    for (int j = 0; j < N_FILT; j++) begin
      filt_o[j] = '0;
      addr_o[j] = '0;
      if (active_i) begin
        filt_o[j] = {26'd0, g_q, 3'(j)};
        addr_o[j] = {26'd0, g_q, 3'(j)} * {22'd0, geom.in_ch} + {23'd0, k_q, 4'd0};
      end
    end
  end

endmodule

// File: rtl/squeeze_weight_fetch.sv
// Streams one squeeze layer of weights/biases to the PE array, one 8-filter x
// 16-channel beat per accepted handshake.
//   state    | meaning
//   IDLE     | waiting for start, outputs hold last beat
//   ISSUE    | loading beats whenever the output register is free
//   DRAIN    | final beat loaded, waiting for its acceptance
module squeeze_weight_fetch
  import squeeze_weight_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             fire_in,
  output logic                   busy,
  output logic                   done,
  squeeze_weight_fetch_if.master bus
);

  logic [1:0]         state_q, state_d;
  logic [2:0]         firesel_q, firesel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [W_OUT_W-1:0] w_q, w_d;
  logic [B_OUT_W-1:0] b_q, b_d;
  logic               clr, adv, load, accept;
  logic               first_k, last_k, last_beat;
  logic [31:0]        addr [N_FILT];
  logic [31:0]        filt [N_FILT];

  sqw_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .adv_i       (adv),
    .active_i    (state_q == ST_ISSUE),
    .fire_i      (firesel_q),
    .addr_o      (addr),
    .filt_o      (filt),
    .first_k_o   (first_k),
    .last_k_o    (last_k),
    .last_beat_o (last_beat)
  );

  assign load   = (state_q == ST_ISSUE) && (!valid_q || bus.out_ready);
  assign accept = valid_q && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    firesel_d = firesel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    first_d   = first_q;
    last_d    = last_q;
    w_d       = w_q;
    b_d       = b_q;
    clr       = 1'b0;
    adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle is already IDLE; a start there must not launch a layer.
        if (start && !done_q) begin
          firesel_d = fire_in;
          busy_d    = 1'b1;
          clr       = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (load) begin
          w_d     = {bus.dataf8, bus.dataf7, bus.dataf6, bus.dataf5,
                     bus.dataf4, bus.dataf3, bus.dataf2, bus.dataf1};
          b_d     = {bus.biasf8, bus.biasf7, bus.biasf6, bus.biasf5,
                     bus.biasf4, bus.biasf3, bus.biasf2, bus.biasf1};
          valid_d = 1'b1;
          first_d = first_k;
          last_d  = last_k;
          adv     = 1'b1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      firesel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      w_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      firesel_q <= firesel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      w_q       <= w_d;
      b_q       <= b_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.firesel   = firesel_q;
  assign bus.w_out     = w_q;
  assign bus.b_out     = b_q;
  assign bus.out_valid = valid_q;
  assign bus.first_grp = first_q;
  assign bus.last_grp  = last_q;

  assign bus.addressf1 = addr[0];
  assign bus.addressf2 = addr[1];
  assign bus.addressf3 = addr[2];
  assign bus.addressf4 = addr[3];
  assign bus.addressf5 = addr[4];
  assign bus.addressf6 = addr[5];
  assign bus.addressf7 = addr[6];
  assign bus.addressf8 = addr[7];

  assign bus.addressfiltf1 = filt[0];
  assign bus.addressfiltf2 = filt[1];
  assign bus.addressfiltf3 = filt[2];
  assign bus.addressfiltf4 = filt[3];
  assign bus.addressfiltf5 = filt[4];
  assign bus.addressfiltf6 = filt[5];
  assign bus.addressfiltf7 = filt[6];
  assign bus.addressfiltf8 = filt[7];

endmodule

// File: tb/tb_squeeze_weight_fetch.sv
// Self-checking bench for squeeze_weight_fetch: a weight-store model answers the
// lane addresses, accepted beats are compared against the layer loop order.
module tb_squeeze_weight_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] fire_in;
  logic       busy;
  logic       done;

  squeeze_weight_fetch_if bus ();

  squeeze_weight_fetch dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .fire_in (fire_in),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  int IN_T  [8] = '{64, 128, 128, 256, 256, 384, 384, 512};
  int OUT_T [8] = '{16, 16, 32, 32, 48, 48, 64, 64};

  // Weight store: 16 words per address, bias per filter index.
  function automatic logic [255:0] line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 16; i++) l[i*16 +: 16] = (a[15:0] + 16'(i * 4099)) ^ 16'hA5A5;
    return l;
  endfunction

  function automatic logic [15:0] bias_of(input logic [31:0] f);
    return 16'(f * 37 + 11);
  endfunction

  always_comb begin
    bus.dataf1 = line(bus.addressf1);  bus.biasf1 = bias_of(bus.addressfiltf1);
    bus.dataf2 = line(bus.addressf2);  bus.biasf2 = bias_of(bus.addressfiltf2);
    bus.dataf3 = line(bus.addressf3);  bus.biasf3 = bias_of(bus.addressfiltf3);
    bus.dataf4 = line(bus.addressf4);  bus.biasf4 = bias_of(bus.addressfiltf4);
    bus.dataf5 = line(bus.addressf5);  bus.biasf5 = bias_of(bus.addressfiltf5);
    bus.dataf6 = line(bus.addressf6);  bus.biasf6 = bias_of(bus.addressfiltf6);
    bus.dataf7 = line(bus.addressf7);  bus.biasf7 = bias_of(bus.addressfiltf7);
    bus.dataf8 = line(bus.addressf8);  bus.biasf8 = bias_of(bus.addressfiltf8);
  end

  // Reference: beat b of fire f is filter group b/nk, channel group b%nk.
  function automatic int nbeats(input int f);
    return (OUT_T[f] / 8) * (IN_T[f] / 16);
  endfunction

  function automatic logic [2047:0] exp_w(input int f, input int b);
    logic [2047:0] w;
    int nk = IN_T[f] / 16;
    int g  = b / nk;
    int k  = b % nk;
    for (int j = 0; j < 8; j++) w[j*256 +: 256] = line(32'((g * 8 + j) * IN_T[f] + k * 16));
    return w;
  endfunction

  function automatic logic [127:0] exp_b(input int f, input int b);
    logic [127:0] v;
    int g = b / (IN_T[f] / 16);
    for (int j = 0; j < 8; j++) v[j*16 +: 16] = bias_of(32'(g * 8 + j));
    return v;
  endfunction

  function automatic logic exp_fg(input int f, input int b);
    return (b % (IN_T[f] / 16)) == 0;
  endfunction

  function automatic logic exp_lg(input int f, input int b);
    return (b % (IN_T[f] / 16)) == (IN_T[f] / 16 - 1);
  endfunction

  typedef struct {
    logic [2047:0] w;
    logic [127:0]  b;
    logic          fg;
    logic          lg;
    int            cyc;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a7;
    logic [31:0] f0;
  } hist_t;

  beat_t got[$];
  hist_t hist[$];
  int t0, done_cnt, done_cyc, done_bad, stall_viol, fsel_viol, timed_out;

  // Runs one layer. mode: 0 ready high, 1 ready toggling 1010.., 2 random ready.
  task automatic run_layer(input int fire, input int mode, input int restart_at, input int abort_at);
    bit prev_stall = 0;
    bit restarted = 0;
    logic [2047:0] sw;
    logic [127:0]  sb;
    logic [31:0]   sa;
    logic          sf, sl;
    got.delete(); hist.delete();
    done_cnt = 0; done_cyc = -1; done_bad = 0; stall_viol = 0; fsel_viol = 0; timed_out = 1;
    @(negedge clk);
    fire_in = 3'(fire); start = 1'b1; bus.out_ready = 1'b1; t0 = cyc;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = 1'b0;
      fire_in = 3'($urandom);
      hist.push_back('{cyc, bus.addressf1, bus.addressf2, bus.addressf8, bus.addressfiltf1});
      if (bus.firesel !== 3'(fire)) fsel_viol++;
      if (done) begin
        done_cnt++; done_cyc = cyc; timed_out = 0;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) done_bad++;
        break;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (n % 2 == 0);
        default: bus.out_ready = 1'($urandom);
      endcase
      if (prev_stall && (bus.w_out !== sw || bus.b_out !== sb || bus.addressf1 !== sa ||
                         bus.first_grp !== sf || bus.last_grp !== sl)) stall_viol++;
      if (abort_at >= 0 && got.size() == abort_at) begin
        rst = 1'b1; timed_out = 0;
        return;
      end
      if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
        start = 1'b1; fire_in = 3'(fire ^ 3); restarted = 1;
      end
      if (bus.out_valid && bus.out_ready)
        got.push_back('{bus.w_out, bus.b_out, bus.first_grp, bus.last_grp, cyc});
      prev_stall = bus.out_valid && !bus.out_ready;
      sw = bus.w_out; sb = bus.b_out; sa = bus.addressf1; sf = bus.first_grp; sl = bus.last_grp;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fire_in = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, bus.out_valid, bus.first_grp, bus.last_grp, bus.firesel} !== 8'd0 ||
        bus.addressf1 !== 0 || bus.addressf8 !== 0 || bus.addressfiltf8 !== 0 ||
        bus.w_out !== '0 || bus.b_out !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b firesel=%0d addr8=%0d, want all 0",
               busy, done, bus.out_valid, bus.firesel, bus.addressf8);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL idle_no_start: got busy=%b valid=%b, want 0 0", busy, bus.out_valid);
    else passed++;
  endtask

  task automatic test_fire0();
    logic [2047:0] ew, gw;
    logic [127:0]  eb;
    run_layer(0, 0, -1, -1);
    total++;
    if (timed_out != 0 || got.size() != 8) $display("FAIL fire0_count: got %0d beats timeout=%0d, want 8 0", got.size(), timed_out);
    else passed++;
    total++;
    if (hist.size() < 5 || hist[0].a1 !== 32'd64 || hist[0].a7 !== 32'd448)
      $display("FAIL fire0_addr_t1: got lane1=%0d lane7=%0d, want 64 448", hist[0].a1, hist[0].a7);
    else passed++;
    total++;
    if (hist.size() < 5 || hist[4].a0 !== 32'd512 || hist[4].f0 !== 32'd8)
      $display("FAIL fire0_beat4_addr: got addr=%0d filt=%0d, want 512 8", hist[4].a0, hist[4].f0);
    else passed++;
    for (int i = 0; i < got.size() && i < nbeats(0); i++) begin
      ew = exp_w(0, i); eb = exp_b(0, i); gw = got[i].w;
      total++;
      if (gw !== ew || got[i].b !== eb || got[i].fg !== exp_fg(0, i) || got[i].lg !== exp_lg(0, i) || got[i].cyc != t0 + 2 + i)
        $display("FAIL fire0_beat%0d: got b=%h fg=%b lg=%b w=%h cyc=%0d, want b=%h fg=%b lg=%b w=%h cyc=%0d",
                 i, got[i].b, got[i].fg, got[i].lg, gw[63:0], got[i].cyc - t0, eb, exp_fg(0, i), exp_lg(0, i), ew[63:0], 2 + i);
      else passed++;
    end
    total++;
    if (done_cyc != t0 + 10 || done_bad != 0 || fsel_viol != 0)
      $display("FAIL fire0_done: got done_at=%0d bad=%0d fsel=%0d, want 10 0 0", done_cyc - t0, done_bad, fsel_viol);
    else passed++;
    // Start during the done cycle must be ignored.
    start = 1'b1; fire_in = 3'd5;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.firesel !== 3'd0)
      $display("FAIL start_on_done: got done=%b busy=%b firesel=%0d, want 0 0 0", done, busy, bus.firesel);
    else passed++;
  endtask

  task automatic test_fire7();
    int bad = 0;
    run_layer(7, 0, -1, -1);
    total++;
    if (timed_out != 0 || got.size() != 256) $display("FAIL fire7_count: got %0d timeout=%0d, want 256 0", got.size(), timed_out);
    else passed++;
    for (int i = 0; i < got.size() && i < 256; i++)
      if (got[i].w !== exp_w(7, i) || got[i].b !== exp_b(7, i) || got[i].cyc != t0 + 2 + i) bad++;
    total++;
    if (bad != 0) $display("FAIL fire7_beats: got %0d bad beats, want 0", bad);
    else passed++;
    total++;
    if (got.size() != 256 || got[255].lg !== 1'b1 || hist.size() < 256 || hist[255].a7 !== 32'd32752)
      $display("FAIL fire7_final: got lg=%b lane7=%0d, want 1 32752", got[got.size() - 1].lg, hist[255].a7);
    else passed++;
  endtask

  task automatic test_stall_fire2();
    logic [2047:0] ew, gw;
    run_layer(2, 1, -1, -1);
    total++;
    if (timed_out != 0 || got.size() != 32 || stall_viol != 0)
      $display("FAIL fire2_stall: got beats=%0d stall_changes=%0d timeout=%0d, want 32 0 0", got.size(), stall_viol, timed_out);
    else passed++;
    for (int i = 0; i < got.size() && i < nbeats(2); i++) begin
      ew = exp_w(2, i); gw = got[i].w;
      total++;
      if (gw !== ew || got[i].b !== exp_b(2, i) || got[i].fg !== exp_fg(2, i) || got[i].lg !== exp_lg(2, i))
        $display("FAIL fire2_beat%0d: got w=%h fg=%b lg=%b, want w=%h fg=%b lg=%b",
                 i, gw[63:0], got[i].fg, got[i].lg, ew[63:0], exp_fg(2, i), exp_lg(2, i));
      else passed++;
    end
  endtask

  task automatic test_restart_ignored();
    int bad = 0;
    run_layer(1, 0, 3, -1);
    for (int i = 0; i < got.size() && i < nbeats(1); i++)
      if (got[i].w !== exp_w(1, i) || got[i].b !== exp_b(1, i)) bad++;
    total++;
    if (timed_out != 0 || got.size() != nbeats(1) || fsel_viol != 0 || bad != 0)
      $display("FAIL restart_ignored: got beats=%0d firesel_changes=%0d bad=%0d, want %0d 0 0",
               got.size(), fsel_viol, bad, nbeats(1));
    else passed++;
  endtask

  task automatic test_reset_midlayer();
    int bad = 0;
    int stray = 0;
    run_layer(4, 0, -1, 5);
    #1;
    total++;
    if (rst !== 1'b1 || {busy, done, bus.out_valid, bus.first_grp, bus.last_grp, bus.firesel} !== 8'd0 ||
        bus.addressf1 !== 0 || bus.addressf8 !== 0 || bus.w_out !== '0 || bus.b_out !== '0)
      $display("FAIL midlayer_reset: got busy=%b valid=%b firesel=%0d addr8=%0d, want 0 0 0 0",
               busy, bus.out_valid, bus.firesel, bus.addressf8);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL midlayer_no_done: got %0d cycles with done/busy, want 0", stray);
    else passed++;
    run_layer(0, 0, -1, -1);
    for (int i = 0; i < got.size() && i < 8; i++)
      if (got[i].w !== exp_w(0, i) || got[i].b !== exp_b(0, i) || got[i].cyc != t0 + 2 + i) bad++;
    total++;
    if (timed_out != 0 || got.size() != 8 || bad != 0 || done_cyc != t0 + 10)
      $display("FAIL post_reset_fire0: got beats=%0d bad=%0d done_at=%0d, want 8 0 10", got.size(), bad, done_cyc - t0);
    else passed++;
  endtask

  task automatic test_flags_fire3();
    int nf = 0;
    int nl = 0;
    int bad = 0;
    run_layer(3, 2, -1, -1);
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].fg) nf++;
      if (got[i].lg) nl++;
      if (i < 64 && (got[i].fg !== ((i % 16) == 0) || got[i].lg !== ((i % 16) == 15) ||
                     got[i].w !== exp_w(3, i))) bad++;
    end
    total++;
    if (timed_out != 0 || got.size() != 64 || nf != 4 || nl != 4 || bad != 0 || stall_viol != 0)
      $display("FAIL fire3_flags: got beats=%0d first=%0d last=%0d bad=%0d stall=%0d, want 64 4 4 0 0",
               got.size(), nf, nl, bad, stall_viol);
    else passed++;
  endtask

  task automatic test_random_layers();
    int f, m, bad;
    for (int r = 0; r < 4; r++) begin
      f = $urandom_range(0, 7);
      m = $urandom_range(0, 2);
      bad = 0;
      run_layer(f, m, -1, -1);
      for (int i = 0; i < got.size() && i < nbeats(f); i++)
        if (got[i].w !== exp_w(f, i) || got[i].b !== exp_b(f, i) ||
            got[i].fg !== exp_fg(f, i) || got[i].lg !== exp_lg(f, i)) bad++;
      total++;
      if (timed_out != 0 || got.size() != nbeats(f) || bad != 0 || stall_viol != 0 || fsel_viol != 0 || done_bad != 0)
        $display("FAIL random%0d_fire%0d_mode%0d: got beats=%0d bad=%0d stall=%0d fsel=%0d, want %0d 0 0 0",
                 r, f, m, got.size(), bad, stall_viol, fsel_viol, nbeats(f));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fire0();
    test_fire7();
    test_stall_fire2();
    test_restart_ignored();
    test_reset_midlayer();
    test_flags_fire3();
    test_random_layers();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time %0t, want completion before 1000000", $time);
    $fatal(1);
  end

endmodule
